bit_serial_alu_seq: RTL and testbench

- Sequencer that drives the team's 1-bit ALU slice (inputs a, b, sm, sa, sb, c_in, op; outputs result, c_out) to perform WIDTH-bit operations serially, LSB first.
- It is the initiator for the combinational slice: it presents operand bits and control, closes the carry loop through a register, and collects result bits into a word.
- Accepts one command per start/ready handshake and reports the word result with carry and zero flags.

---
 rtl/bit_serial_alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer for the 1-bit ALU slice: runs WIDTH-bit commands LSB first.
// Optional signed-overflow flag enabled by defining BSALU_OVF_FLAG_EN.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_sm,
  output logic             slice_sa,
  output logic             slice_sb,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       sa;
    logic       sb;
    logic       sm;
    logic       cinit;
    logic       cfb;
  } ctl_t;

  function automatic ctl_t decode(input logic [2:0] c);
    ctl_t d;
    case (c)
      3'b000:  d = '{op: 2'b00, sa: 1'b0, sb: 1'b0, sm: 1'b0, cinit: 1'b0, cfb: 1'b0};
      3'b001:  d = '{op: 2'b01, sa: 1'b0, sb: 1'b0, sm: 1'b0, cinit: 1'b0, cfb: 1'b0};
      3'b010:  d = '{op: 2'b10, sa: 1'b0, sb: 1'b0, sm: 1'b0, cinit: 1'b0, cfb: 1'b1};
      3'b011:  d = '{op: 2'b10, sa: 1'b0, sb: 1'b1, sm: 1'b0, cinit: 1'b1, cfb: 1'b1};
      3'b100:  d = '{op: 2'b10, sa: 1'b0, sb: 1'b0, sm: 1'b0, cinit: 1'b0, cfb: 1'b0};
      3'b101:  d = '{op: 2'b01, sa: 1'b1, sb: 1'b1, sm: 1'b0, cinit: 1'b0, cfb: 1'b0};
      3'b110:  d = '{op: 2'b00, sa: 1'b1, sb: 1'b1, sm: 1'b0, cinit: 1'b0, cfb: 1'b0};
      default: d = '{op: 2'b11, sa: 1'b0, sb: 1'b0, sm: 1'b1, cinit: 1'b0, cfb: 1'b0};
    endcase
    return d;
  endfunction

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa_sr, opb_sr, acc, acc_nx;
  logic [2:0]       cmd_q;
  logic [CW-1:0]    bitcnt;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_o, zero_o;
  ctl_t             ctl;
  logic             last_bit;

  assign ctl      = decode(cmd_q);
  assign acc_nx   = {slice_result, acc[WIDTH-1:1]};
  assign last_bit = (bitcnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Flags are captured on the final RUN edge so they are already valid in DONE and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_sr   <= '0;
      opb_sr   <= '0;
      acc      <= '0;
      cmd_q    <= '0;
      bitcnt   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      carry_o  <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa_sr  <= opa;
            opb_sr  <= opb;
            cmd_q   <= cmd;
            acc     <= '0;
            bitcnt  <= '0;
            carry_q <= decode(cmd).cinit;
          end
        end
        S_RUN: begin
          opa_sr  <= opa_sr >> 1;
          opb_sr  <= opb_sr >> 1;
          acc     <= acc_nx;
          carry_q <= slice_cout;
          bitcnt  <= bitcnt + CW'(1);
          if (last_bit) begin
            result_q <= acc_nx;
            carry_o  <= ctl.cfb & slice_cout;
            zero_o   <= (acc_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BSALU_OVF_FLAG_EN
  // Carry into the MSB xor carry out of the MSB; only ADD/SUB close the carry loop.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == S_RUN && last_bit) begin
      ovf_q <= ctl.cfb & (slice_cin ^ slice_cout);
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_sm  = 1'b0;
    slice_sa  = 1'b0;
    slice_sb  = 1'b0;
    slice_cin = 1'b0;
    slice_op  = 2'b00;
    case (state)
      S_IDLE: ready = 1'b1;
      S_RUN: begin
        slice_a   = opa_sr[0];
        slice_b   = opb_sr[0];
        slice_sm  = ctl.sm;
        slice_sa  = ctl.sa;
        slice_sb  = ctl.sb;
        slice_cin = ctl.cfb & carry_q;
        slice_op  = ctl.op;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;
  assign carry  = carry_o;
  assign zero   = zero_o;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench for bit_serial_alu_seq with a behavioural model of the 1-bit ALU slice.
module tb_bit_serial_alu_seq;
  localparam int W = 8;
`ifdef BSALU_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   cmd = '0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         ready, done, carry, zero, ovf;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_sm, slice_sa, slice_sb, slice_cin;
  logic [1:0]   slice_op;
  logic         slice_result, slice_cout;

  always #5 clk = ~clk;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
    .ready(ready), .done(done), .result(result), .carry(carry), .zero(zero), .ovf(ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_sm(slice_sm), .slice_sa(slice_sa),
    .slice_sb(slice_sb), .slice_cin(slice_cin), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  logic sl_a, sl_b;
  assign sl_a = slice_a ^ slice_sa;
  assign sl_b = slice_b ^ slice_sb;
  assign slice_cout = (sl_a & sl_b) | (sl_a & slice_cin) | (sl_b & slice_cin);
  always_comb begin
    slice_result = 1'b0;
    case (slice_op)
      2'b00: slice_result = sl_a & sl_b;
      2'b01: slice_result = sl_a | sl_b;
      2'b10: slice_result = sl_a ^ sl_b ^ slice_cin;
      2'b11: slice_result = slice_sm;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, v;
    int           acc_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("ready_after_done", 32'(ready), 32'd1);
      end
      prev_done = done;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, 32'(result), 32'(e.res));
          chk({e.name, "_carry"}, 32'(carry), 32'(e.c));
          chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
          chk({e.name, "_ovf"}, 32'(ovf), 32'(e.v));
          chk({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(W));
        end
      end
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (i == 50) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (i == 30) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                       input logic ez, input logic ev, input bit pulse);
    exp_t e;
    wait_ready();
    start = 1'b1; cmd = c; opa = a; opb = b;
    e.res = er; e.c = ec; e.z = ez; e.v = ev; e.acc_cyc = cyc + 1; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; cmd = 3'($urandom); opa = W'($urandom); opb = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      start = pulse && (k == 2 || k == 5);
      if (start) begin
        cmd = 3'b111; opa = W'($urandom); opb = W'($urandom);
      end
    end
    start = 1'b0;
    wait_drain();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_result"}, 32'(result), 32'd0);
    chk({nm, "_flags"}, {29'd0, carry, zero, ovf}, 32'd0);
    chk({nm, "_slice"}, {24'd0, slice_a, slice_b, slice_sm, slice_sa, slice_sb, slice_cin, slice_op},
        32'd0);
  endtask

  initial begin
    #23;
    chk_reset_state("por");
    @(negedge clk); rst_n = 1'b1;

    do_op("add_3c_05",   3'b010, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("add_ff_01",   3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0,   1'b0);
    do_op("sub_05_07",   3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("sub_07_05",   3'b011, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0,   1'b0);
    do_op("and_f0_3c",   3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("or_f0_0c",    3'b001, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("nand_f0_3c",  3'b101, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("nor_f0_0f",   3'b110, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0,   1'b0);
    do_op("xor_aa_ff",   3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("set",         3'b111, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("add_7f_01",   3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, OVF_EN, 1'b0);
    do_op("sub_80_01",   3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, OVF_EN, 1'b0);
    do_op("add_10_10",   3'b010, 8'h10, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0,   1'b0);
    do_op("add_ignore",  3'b010, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0,   1'b1);
    repeat (12) @(negedge clk);
    do_op("set_pre_rst", 3'b111, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0,   1'b0);

    // SUB aborted by reset during bit 4: no done may follow
    wait_ready();
    start = 1'b1; cmd = 3'b011; opa = 8'h07; opb = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("mid_run_rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);

    do_op("add_01_01",   3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0,   1'b0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
